// File: rtl/ucie_ctl_sb_tx_arbiter.sv
// Round-robin arbiter that sequences N_REQ sideband message sources onto a single TX FSM,
// with an acceptance timeout and an idle gap after every message.
module ucie_ctl_sb_tx_arbiter #(
  parameter int N_REQ    = 3,
  parameter int MSG_W    = 64,
  parameter int TIMEOUT  = 16,
  parameter int IDLE_GAP = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*MSG_W-1:0]   i_msg,
  output logic [N_REQ-1:0]         o_gnt,
  output logic [N_REQ-1:0]         o_done,
  output logic                     o_timeout,
  output logic [$clog2(N_REQ)-1:0] o_err_id,
  output logic                     o_valid_lp_sb,
  output logic [MSG_W-1:0]         o_msg,
  input  logic                     i_pl_sb_busy,
  output logic [$clog2(N_REQ)-1:0] o_active_id
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int TO_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               timeout_q, timeout_d;
  logic [ID_W-1:0]    err_id_q, err_id_d;
  logic               valid_q, valid_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic [ID_W-1:0]    active_id_q, active_id_d;

  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic [MSG_W-1:0]   win_msg;
  logic [N_REQ-1:0]   owner_onehot;
  logic [ID_W-1:0]    owner_next;

  // Search starts at the pointer and wraps, so the last-served requester is checked last.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_msg   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!win_found && i_req[k] && (((int'(ptr_q) + i) % N_REQ) == k)) begin
          win_found = 1'b1;
          win_id    = ID_W'(k);
          win_msg   = i_msg[k*MSG_W +: MSG_W];
        end
      end
    end
  end

  assign owner_onehot = N_REQ'(1) << active_id_q;
  assign owner_next   = (active_id_q == ID_W'(N_REQ - 1)) ? '0 : active_id_q + ID_W'(1);

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned and infers a latch.
    state_d     = state_q;
    ptr_d       = ptr_q;
    to_cnt_d    = to_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    gnt_d       = '0;
    done_d      = '0;
    timeout_d   = 1'b0;
    err_id_d    = err_id_q;
    valid_d     = valid_q;
    msg_d       = msg_q;
    active_id_d = active_id_q;

    unique case (state_q)
      S_IDLE: begin
        if (!i_pl_sb_busy && win_found) begin
          state_d     = S_ISSUE;
          gnt_d       = N_REQ'(1) << win_id;
          valid_d     = 1'b1;
          msg_d       = win_msg;
          active_id_d = win_id;
          to_cnt_d    = '0;
        end
      end
      S_ISSUE: begin
        // Acceptance wins over a timeout expiring in the same cycle.
        if (i_pl_sb_busy) begin
          valid_d = 1'b0;
          state_d = S_WAIT_DONE;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          valid_d   = 1'b0;
          timeout_d = 1'b1;
          err_id_d  = active_id_q;
          ptr_d     = owner_next;
          gap_cnt_d = '0;
          state_d   = (IDLE_GAP == 0) ? S_IDLE : S_GAP;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!i_pl_sb_busy) begin
          done_d    = owner_onehot;
          ptr_d     = owner_next;
          gap_cnt_d = '0;
          state_d   = (IDLE_GAP == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_W'(IDLE_GAP - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (i_rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      to_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      timeout_q   <= 1'b0;
      err_id_q    <= '0;
      valid_q     <= 1'b0;
      msg_q       <= '0;
      active_id_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      to_cnt_q    <= to_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      err_id_q    <= err_id_d;
      valid_q     <= valid_d;
      msg_q       <= msg_d;
      active_id_q <= active_id_d;
    end
  end

  assign o_gnt         = gnt_q;
  assign o_done        = done_q;
  assign o_timeout     = timeout_q;
  assign o_err_id      = err_id_q;
  assign o_valid_lp_sb = valid_q;
  assign o_msg         = msg_q;
  assign o_active_id   = active_id_q;

endmodule

// File: tb/tb_ucie_ctl_sb_tx_arbiter.sv
// Directed bench: a vector table for the 3-requester arbiter plus hand-written timeout,
// credit-stall, mid-transfer reset and IDLE_GAP=0 sequences.
module tb_ucie_ctl_sb_tx_arbiter;

  localparam logic [63:0] M0 = 64'hA5A5_0000_1234_5678;
  localparam logic [63:0] M1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] M2 = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [63:0] N0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] N1 = 64'hFEDC_BA98_7654_3210;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  req, gnt, done;
  logic        busy, to, valid;
  logic [1:0]  err_id, act;
  logic [63:0] msg;

  logic [1:0]  req2, gnt2, done2;
  logic        busy2, to2, valid2;
  logic [0:0]  err2, act2;
  logic [63:0] msg2;

  ucie_ctl_sb_tx_arbiter #(.N_REQ(3), .MSG_W(64), .TIMEOUT(16), .IDLE_GAP(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_msg({M2, M1, M0}),
    .o_gnt(gnt), .o_done(done), .o_timeout(to), .o_err_id(err_id),
    .o_valid_lp_sb(valid), .o_msg(msg), .i_pl_sb_busy(busy), .o_active_id(act)
  );

  ucie_ctl_sb_tx_arbiter #(.N_REQ(2), .MSG_W(64), .TIMEOUT(4), .IDLE_GAP(0)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_req(req2), .i_msg({N1, N0}),
    .o_gnt(gnt2), .o_done(done2), .o_timeout(to2), .o_err_id(err2),
    .o_valid_lp_sb(valid2), .o_msg(msg2), .i_pl_sb_busy(busy2), .o_active_id(act2)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic        busy;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic        valid;
    logic        to;
    logic [1:0]  act;
    logic [63:0] msg;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(logic r, logic [2:0] q, logic b, logic [2:0] g, logic [2:0] d,
                              logic v, logic t, logic [1:0] a, logic [63:0] m);
    vec_t x;
    x.rst = r; x.req = q; x.busy = b; x.gnt = g; x.done = d;
    x.valid = v; x.to = t; x.act = a; x.msg = m;
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act_v, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    rst = 1'b1; req = '0; busy = 1'b0; req2 = '0; busy2 = 1'b0;

    //            rst req    busy gnt    done   v  to act msg
    vecs.push_back(mk(1, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0, 64'h0));
    vecs.push_back(mk(0, 3'b001, 0, 3'b001, 3'b000, 1, 0, 0, M0));
    vecs.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 1, 0, 0, M0));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(0, 3'b000, 1, 3'b000, 3'b000, 0, 0, 0, M0));
    vecs.push_back(mk(0, 3'b000, 0, 3'b000, 3'b001, 0, 0, 0, M0));
    vecs.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0, M0));
    vecs.push_back(mk(0, 3'b111, 0, 3'b010, 3'b000, 1, 0, 1, M1));
    vecs.push_back(mk(0, 3'b111, 1, 3'b000, 3'b000, 0, 0, 1, M1));
    vecs.push_back(mk(0, 3'b111, 0, 3'b000, 3'b010, 0, 0, 1, M1));
    vecs.push_back(mk(0, 3'b111, 0, 3'b000, 3'b000, 0, 0, 1, M1));
    vecs.push_back(mk(0, 3'b111, 0, 3'b100, 3'b000, 1, 0, 2, M2));
    vecs.push_back(mk(0, 3'b111, 1, 3'b000, 3'b000, 0, 0, 2, M2));
    vecs.push_back(mk(0, 3'b111, 0, 3'b000, 3'b100, 0, 0, 2, M2));
    vecs.push_back(mk(0, 3'b111, 0, 3'b000, 3'b000, 0, 0, 2, M2));
    vecs.push_back(mk(0, 3'b111, 0, 3'b001, 3'b000, 1, 0, 0, M0));
    vecs.push_back(mk(0, 3'b111, 1, 3'b000, 3'b000, 0, 0, 0, M0));
    vecs.push_back(mk(0, 3'b111, 0, 3'b000, 3'b001, 0, 0, 0, M0));
    vecs.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0, M0));
    vecs.push_back(mk(0, 3'b100, 1, 3'b000, 3'b000, 0, 0, 0, M0));
    vecs.push_back(mk(0, 3'b100, 0, 3'b100, 3'b000, 1, 0, 2, M2));
    vecs.push_back(mk(0, 3'b000, 1, 3'b000, 3'b000, 0, 0, 2, M2));
    vecs.push_back(mk(0, 3'b000, 0, 3'b000, 3'b100, 0, 0, 2, M2));
    vecs.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 0, 0, 2, M2));

    foreach (vecs[i]) begin
      rst = vecs[i].rst; req = vecs[i].req; busy = vecs[i].busy;
      tick();
      check($sformatf("row%0d gnt", i),   gnt,   vecs[i].gnt);
      check($sformatf("row%0d done", i),  done,  vecs[i].done);
      check($sformatf("row%0d valid", i), valid, vecs[i].valid);
      check($sformatf("row%0d tmo", i),   to,    vecs[i].to);
      check($sformatf("row%0d act", i),   act,   vecs[i].act);
      check($sformatf("row%0d msg", i),   msg,   vecs[i].msg);
    end

    // Timeout: busy never rises, valid must stay high for exactly TIMEOUT cycles.
    req = 3'b010; busy = 1'b0; tick();
    check("to_gnt", gnt, 3'b010);
    req = 3'b000; n = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!valid) break;
      n++;
    end
    check("to_valid_len", n, 16);
    check("to_pulse", to, 1'b1);
    check("to_err_id", err_id, 2'd1);
    check("to_no_done", done, 3'b000);
    tick();
    check("to_pulse_end", to, 1'b0);
    req = 3'b111; tick();
    check("to_ptr_adv", gnt, 3'b100);
    req = 3'b000; busy = 1'b1; tick();
    busy = 1'b0; tick();
    check("to_next_done", done, 3'b100);
    tick();

    // Credit stall: busy held 200 cycles, then done and the pending grant at c+3.
    req = 3'b001; tick();
    check("st_gnt0", gnt, 3'b001);
    req = 3'b010; busy = 1'b1; tick();
    bad = 0;
    for (int i = 0; i < 199; i++) begin
      tick();
      if (done != 3'b000 || to || gnt != 3'b000 || valid) bad++;
    end
    check("st_quiet", bad, 0);
    busy = 1'b0; tick();
    check("st_done", done, 3'b001);
    check("st_no_to", to, 1'b0);
    n = 0;
    while (gnt == 3'b000 && n < 10) begin
      tick();
      n++;
    end
    check("st_gnt_lat", n, 2);
    check("st_gnt1", gnt, 3'b010);

    // Reset while requester 1 sits in WAIT_DONE.
    req = 3'b011; busy = 1'b1; tick();
    check("rs_wait_valid", valid, 1'b0);
    rst = 1'b1; tick();
    check("rs_gnt", gnt, 3'b000);
    check("rs_done", done, 3'b000);
    check("rs_valid", valid, 1'b0);
    check("rs_tmo", to, 1'b0);
    check("rs_err_id", err_id, 2'd0);
    check("rs_act", act, 2'd0);
    check("rs_msg", msg, 64'h0);
    rst = 1'b0; busy = 1'b0; tick();
    check("rs_regrant_ptr0", gnt, 3'b001);
    check("rs_no_done", done, 3'b000);
    req = 3'b000; busy = 1'b1; tick();
    busy = 1'b0; tick();
    check("rs_done_after", done, 3'b001);
    tick();

    // N_REQ=2, IDLE_GAP=0, TIMEOUT=4 instance.
    req2 = 2'b11; busy2 = 1'b0; tick();
    check("g0_gnt0", gnt2, 2'b01);
    check("g0_valid", valid2, 1'b1);
    check("g0_msg", msg2, N0);
    busy2 = 1'b1; tick();
    check("g0_valid_drop", valid2, 1'b0);
    busy2 = 1'b0; tick();
    check("g0_done0", done2, 2'b01);
    tick();
    check("g0_b2b_gnt1", gnt2, 2'b10);
    check("g0_act1", act2, 1'b1);
    check("g0_msg1", msg2, N1);
    req2 = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("g0_hold%0d", i), valid2, 1'b1);
    end
    busy2 = 1'b1; tick();
    check("g0_race_no_to", to2, 1'b0);
    check("g0_race_valid", valid2, 1'b0);
    busy2 = 1'b0; tick();
    check("g0_done1", done2, 2'b10);
    req2 = 2'b10; tick();
    check("g0_gnt1b", gnt2, 2'b10);
    req2 = 2'b00; n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!valid2) break;
      n++;
    end
    check("g0_valid_len", n, 4);
    check("g0_to_pulse", to2, 1'b1);
    check("g0_err_id", err2, 1'b1);
    check("g0_to_no_done", done2, 2'b00);
    req2 = 2'b11; tick();
    check("g0_gnt_after_to", gnt2, 2'b01);
    check("g0_to_end", to2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ucie_ctl_sb_tx_arbiter.md
Name: ucie_ctl_sb_tx_arbiter

Overview:
Round-robin arbiter and sequencer sharing the sideband TX path among N_REQ message sources, such as link-management, register-access and error-reporting agents. It captures one message at a time, drives the valid/busy handshake into the sideband TX FSM, and reports completion or timeout back to the owning requester. It also enforces a configurable idle gap between messages so the TX FSM settles in its idle state.

Parameters:
N_REQ, 3, number of requesters (2..8)
MSG_W, 64, message width in bits
TIMEOUT, 16, max cycles valid may be held without busy rising (>=2)
IDLE_GAP, 1, idle cycles inserted after each message (0..15)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; reset is synchronous and active-high
i_req  in  N_REQ  per-requester request level; held until grant
i_msg  in  N_REQ*MSG_W  packed messages; requester k uses bits [k*MSG_W +: MSG_W]
o_gnt  out  N_REQ  one-hot, 1-cycle pulse: message captured
o_done  out  N_REQ  one-hot, 1-cycle pulse: message fully sent
o_timeout  out  1  1-cycle pulse: TX FSM never accepted the message
o_err_id  out  clog2(N_REQ)  id of the timed-out requester; holds until the next timeout
o_valid_lp_sb  out  1  message valid to the TX FSM
o_msg  out  MSG_W  captured message to the TX FSM
i_pl_sb_busy  in  1  TX FSM busy, high from acceptance through credit wait
o_active_id  out  clog2(N_REQ)  id of the current owner

Behaviour:
- Reset (sampled on rising i_clk while i_rst=1):
  - all outputs 0, state IDLE, round-robin pointer 0, counters 0.
  - Applies mid-operation too; the in-flight message is dropped with no done or timeout pulse.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_DONE, GAP.
- IDLE:
  - Arbitration occurs only if i_pl_sb_busy=0 and i_req!=0.
  - Winner is the lowest index k at or above the pointer, wrapping modulo N_REQ.
  - At the edge: r_msg<=i_msg[k], o_active_id<=k, o_gnt<=onehot(k), o_valid_lp_sb<=1, state<=ISSUE.
  - Latency: request sampled in cycle t gives gnt, valid and msg in cycle t+1.
  - A request dropped before being sampled is never granted.
- ISSUE:
  - o_valid_lp_sb=1 and o_msg stable; the timeout counter starts at 0 on entry.
  - i_pl_sb_busy=1 at the edge: valid<=0, state<=WAIT_DONE.
  - Otherwise, when the counter reaches TIMEOUT-1: valid<=0, o_timeout<=1, o_err_id<=owner, pointer<=owner+1 mod N_REQ, state<=GAP, or IDLE if IDLE_GAP=0.
  - Valid is therefore high for exactly TIMEOUT cycles on timeout.
  - Busy rising in the same cycle as counter expiry takes precedence: normal path, no timeout.
- WAIT_DONE:
  - Has no timeout, since credit starvation may hold busy indefinitely.
  - i_pl_sb_busy=0 sampled in cycle c: o_done[owner]=1 in c+1, pointer<=owner+1 mod N_REQ, state<=GAP, or IDLE if IDLE_GAP=0.
- GAP:
  - Lasts exactly IDLE_GAP cycles, then IDLE.
  - Earliest next grant is in cycle c+IDLE_GAP+2.
- Requests arriving outside IDLE, including a re-request by the current owner, are held pending and arbitrated on return to IDLE.
- Fairness: after being served, requester k has the lowest priority in the next arbitration.
- Busy already high in IDLE (external use) blocks granting until it falls.
- Counter widths: clog2(TIMEOUT) and clog2(IDLE_GAP+1), minimum 1 bit; no wrap-around is possible.

Test Plan:
- Single message: i_req=3'b001, msg0=64'hA5A5_0000_1234_5678. Required: gnt=001, valid=1 and o_msg=msg0 next cycle. TX raises busy 1 cycle later, so valid drops. Busy held 6 cycles then falls: done=001 one cycle later, o_active_id=0.
- Round-robin: i_req=3'b111 held, pointer 0 → grant order 0,1,2,0. Re-asserting req0 during owner 1's transfer does not preempt; requester 2 is served before 0.
- Timeout: busy tied 0, TIMEOUT=16 → valid high exactly 16 cycles, o_timeout pulse, o_err_id=owner, no done pulse, pointer advances.
- Credit stall: busy held high 200 cycles → no timeout, done only 1 cycle after busy falls; a pending req1 is granted at c+IDLE_GAP+2 (c+3 with IDLE_GAP=1).
- Reset mid WAIT_DONE: pulse i_rst for 1 cycle → all outputs 0 next cycle, no done, pointer 0. Pending i_req=010 is granted 1 cycle after reset releases.
- Edge case IDLE_GAP=0 and N_REQ=2: back-to-back grants at c+2; busy rising on the same cycle as counter expiry gives no timeout.
